// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and helpers for the instruction fetch unit.
//   XLEN_DEF      : default PC / address / instruction width
//   fetch_entry_t : one buffered instruction tagged with its aligned PC
//   align_pc()    : clears the byte-offset bits of a PC (word alignment)
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int XLEN_DEF = 32;

  // Field order (pc in the upper half) is the packing used by the output
  // queue in instr_fetch_unit.
  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN_DEF-1:0] align_pc(input logic [XLEN_DEF-1:0] pc);
    return {pc[XLEN_DEF-1:2], 2'b00};
  endfunction

endpackage : fetch_pkg

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO with flush, used for the in-order PC tag queue and the
// decoded-instruction output queue of instr_fetch_unit.
//   clk_i    : clock, rising edge
//   rst_i    : asynchronous reset, active high
//   push_i   : write wdata_i (accepted when not full, or full with pop_i)
//   wdata_i  : write data
//   pop_i    : drop the head entry (ignored when empty)
//   flush_i  : empty the FIFO; wins over push/pop in the same cycle
//   rdata_o  : head entry (storage is flops, so this is a registered value)
//   full_o   : DEPTH entries held
//   empty_o  : no entries held
//   count_o  : number of entries held, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Push into a full FIFO is legal only when the head leaves in the same cycle.
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap naturally: DEPTH is a power of two.
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Data storage needs no reset; validity is carried by count_q.
  always_ff @(posedge clk_i) begin
    if (push_ok && !flush_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && full_o && !pop_i && !flush_i));

endmodule : fetch_fifo

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Takes fetch PCs, issues word-aligned reads to instruction memory over a
// req/gnt + in-order rvalid protocol, and hands returned instructions (tagged
// with their PC) to decode over valid/ready. A flush drops everything buffered
// and arranges for in-flight responses to be silently discarded.
//   i_clk          : clock, rising edge
//   i_reset        : asynchronous reset, active high
//   i_req_valid    : fetch PC valid
//   i_req_pc       : fetch PC
//   o_req_ready    : PC accepted this cycle (request granted)
//   o_imem_req     : memory read request
//   o_imem_addr    : word-aligned i_req_pc
//   i_imem_gnt     : memory accepts the request this cycle
//   i_imem_rvalid  : read data valid (in order, >= 1 cycle after grant)
//   i_imem_rdata   : read data
//   i_flush        : redirect; drop buffered and in-flight fetches
//   o_instr_valid  : instruction available
//   o_instr        : instruction
//   o_instr_pc     : aligned PC of o_instr
//   i_instr_ready  : decode consumes the instruction
//   o_err          : sticky; a response arrived with nothing outstanding
// -----------------------------------------------------------------------------
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = XLEN_DEF
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_req_valid,
  input  logic [XLEN-1:0] i_req_pc,
  output logic            o_req_ready,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvalid,
  input  logic [XLEN-1:0] i_imem_rdata,
  input  logic            i_flush,
  output logic            o_instr_valid,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_instr_pc,
  input  logic            i_instr_ready,
  output logic            o_err
);

  localparam int CW      = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = 2 * XLEN;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;
  logic          err_q, err_d;

  logic [XLEN-1:0]    pc_aligned;
  logic [XLEN-1:0]    pcq_head;
  logic               pcq_empty, pcq_full;
  logic [CW-1:0]      pcq_count;

  logic [ENTRY_W-1:0] outq_wdata, outq_head;
  logic               outq_empty, outq_full;
  logic [CW-1:0]      outq_count;

  logic [CW:0] credit_total;
  logic        credit_ok;
  logic        issue;
  logic        resp_discard;
  logic        resp_orphan;
  logic        resp_accept;
  logic        flush_sub;
  logic        instr_pop;

  // Masking (rather than slicing) keeps every bit of i_req_pc in use.
  assign pc_aligned  = i_req_pc & ~XLEN'(3);
  assign o_imem_addr = pc_aligned;

  // Credits released this cycle only show up next cycle because every term
  // here is a register.
  assign credit_total = {1'b0, outstanding_q} + {1'b0, outq_count} + {1'b0, discard_q};
  assign credit_ok    = (credit_total < DEPTH_C);

  assign o_imem_req  = ~i_reset & i_req_valid & credit_ok & ~i_flush;
  assign o_req_ready = o_imem_req & i_imem_gnt;
  assign issue       = o_req_ready;

  // Response classification: discards take precedence, then normal returns,
  // and anything left over has no matching request.
  assign resp_discard = i_imem_rvalid & (discard_q != '0);
  assign resp_orphan  = i_imem_rvalid & (discard_q == '0) & pcq_empty;
  assign resp_accept  = i_imem_rvalid & (discard_q == '0) & ~pcq_empty & ~i_flush;

  // On flush, the in-flight response of this cycle (if it had an owner) is
  // retired immediately instead of being added to the discard count.
  assign flush_sub = i_imem_rvalid & ~resp_orphan;

  assign instr_pop = o_instr_valid & i_instr_ready;

  always_comb begin
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    err_d         = err_q | resp_orphan;
    if (i_flush) begin
      outstanding_d = '0;
      discard_d     = discard_q + outstanding_q - CW'(flush_sub);
    end else begin
      outstanding_d = outstanding_q + CW'(issue) - CW'(resp_accept);
      discard_d     = discard_q - CW'(resp_discard);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      outstanding_q <= '0;
      discard_q     <= '0;
      err_q         <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      err_q         <= err_d;
    end
  end

  assign o_err = err_q;

  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_pc_q (
    .clk_i   (i_clk),
    .rst_i   (i_reset),
    .push_i  (issue),
    .wdata_i (pc_aligned),
    .pop_i   (resp_accept),
    .flush_i (i_flush),
    .rdata_o (pcq_head),
    .full_o  (pcq_full),
    .empty_o (pcq_empty),
    .count_o (pcq_count)
  );

  // Entry layout {pc, instr} matches fetch_entry_t at the default width.
  assign outq_wdata = {pcq_head, i_imem_rdata};

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_out_q (
    .clk_i   (i_clk),
    .rst_i   (i_reset),
    .push_i  (resp_accept),
    .wdata_i (outq_wdata),
    .pop_i   (instr_pop),
    .flush_i (i_flush),
    .rdata_o (outq_head),
    .full_o  (outq_full),
    .empty_o (outq_empty),
    .count_o (outq_count)
  );

  assign o_instr_valid = ~outq_empty;
  assign o_instr_pc    = outq_head[ENTRY_W-1:XLEN];
  assign o_instr       = outq_head[XLEN-1:0];

  logic unused_status;
  assign unused_status = ^{pcq_full, pcq_count, outq_full};

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_pc;
  logic        req_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        flush;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.DEPTH(2), .XLEN(32)) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_req_valid   (req_valid),
    .i_req_pc      (req_pc),
    .o_req_ready   (req_ready),
    .o_imem_req    (imem_req),
    .o_imem_addr   (imem_addr),
    .i_imem_gnt    (gnt),
    .i_imem_rvalid (rvalid),
    .i_imem_rdata  (rdata),
    .i_flush       (flush),
    .o_instr_valid (instr_valid),
    .o_instr       (instr),
    .o_instr_pc    (instr_pc),
    .i_instr_ready (instr_ready),
    .o_err         (err)
  );

  // Inputs change 1 time unit after a rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 0; req_pc = '0; gnt = 0; rvalid = 0; rdata = '0;
    flush = 0; instr_ready = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    req_valid = 1; req_pc = 32'h40; gnt = 1;
    tick(); tick();
    #1;
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
    n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", req_ready); end
    n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    idle_inputs();
    tick();
    rst = 0;
    tick();
  endtask

  task automatic test_basic();
    req_valid = 1; req_pc = 32'h100; gnt = 1;
    #1;
    n_tests++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL basic_req: got %b want 1", imem_req); end
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready: got %b want 1", req_ready); end
    n_tests++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL basic_addr: got %h want 00000100", imem_addr); end
    tick();
    req_valid = 0; gnt = 0; rvalid = 1; rdata = 32'h0000_0093;
    #1;
    n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b want 0", instr_valid); end
    tick();
    rvalid = 0;
    #1;
    n_tests++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", instr_valid); end
    n_tests++; if (instr !== 32'h0000_0093) begin n_fail++; $display("FAIL basic_instr: got %h want 00000093", instr); end
    n_tests++; if (instr_pc !== 32'h100) begin n_fail++; $display("FAIL basic_pc: got %h want 00000100", instr_pc); end
    instr_ready = 1;
    tick();
    instr_ready = 0;
    #1;
    n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain: got %b want 0", instr_valid); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b want 0", err); end
  endtask

  task automatic test_align();
    req_valid = 1; req_pc = 32'h0000_0106; gnt = 1;
    #1;
    n_tests++; if (imem_addr !== 32'h0000_0104) begin n_fail++; $display("FAIL align_addr: got %h want 00000104", imem_addr); end
    tick();
    req_valid = 0; gnt = 0; rvalid = 1; rdata = 32'h1234_5678;
    tick();
    rvalid = 0;
    #1;
    n_tests++; if (instr_pc !== 32'h0000_0104) begin n_fail++; $display("FAIL align_pc: got %h want 00000104", instr_pc); end
    n_tests++; if (instr !== 32'h1234_5678) begin n_fail++; $display("FAIL align_instr: got %h want 12345678", instr); end
    instr_ready = 1;
    tick();
    instr_ready = 0;
  endtask

  task automatic test_credit();
    instr_ready = 0;
    req_valid = 1; req_pc = 32'h300; gnt = 1;
    #1;
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL credit_g1: got %b want 1", req_ready); end
    tick();
    req_pc = 32'h304;
    #1;
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL credit_g2: got %b want 1", req_ready); end
    tick();
    req_pc = 32'h308;
    #1;
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL credit_block_out2: got %b want 0", imem_req); end
    rvalid = 1; rdata = 32'h11;
    #1;
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL credit_no_bypass_resp: got %b want 0", imem_req); end
    tick();
    rdata = 32'h22;
    #1;
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL credit_block_mix: got %b want 0", imem_req); end
    tick();
    rvalid = 0;
    #1;
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL credit_block_full: got %b want 0", imem_req); end
    n_tests++; if (instr !== 32'h11 || instr_pc !== 32'h300) begin n_fail++; $display("FAIL credit_first: got %h@%h want 00000011@00000300", instr, instr_pc); end
    instr_ready = 1;
    #1;
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL credit_no_bypass_pop: got %b want 0", imem_req); end
    tick();
    instr_ready = 0;
    #1;
    n_tests++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL credit_unblock: got %b want 1", imem_req); end
    n_tests++; if (instr !== 32'h22 || instr_pc !== 32'h304) begin n_fail++; $display("FAIL credit_second: got %h@%h want 00000022@00000304", instr, instr_pc); end
    tick();
    req_valid = 0; gnt = 0; rvalid = 1; rdata = 32'h33; instr_ready = 1;
    tick();
    rvalid = 0;
    #1;
    n_tests++; if (instr_valid !== 1'b1 || instr !== 32'h33 || instr_pc !== 32'h308) begin n_fail++; $display("FAIL credit_third: got v=%b %h@%h want 1 00000033@00000308", instr_valid, instr, instr_pc); end
    tick();
    instr_ready = 0;
    #1;
    n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL credit_drained: got %b want 0", instr_valid); end
  endtask

  task automatic test_flush();
    req_valid = 1; req_pc = 32'h400; gnt = 1;
    tick();
    req_pc = 32'h404;
    tick();
    req_pc = 32'h408; flush = 1;
    #1;
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL flush_no_issue: got %b want 0", imem_req); end
    tick();
    flush = 0; req_valid = 0; gnt = 0;
    #1;
    n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", instr_valid); end
    rvalid = 1; rdata = 32'hAAAA;
    tick();
    rdata = 32'hBBBB;
    tick();
    rvalid = 0;
    #1;
    n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL flush_dropped: got %b want 0", instr_valid); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL flush_err: got %b want 0", err); end
    req_valid = 1; req_pc = 32'h200; gnt = 1;
    #1;
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL flush_reissue: got %b want 1", req_ready); end
    tick();
    req_valid = 0; gnt = 0; rvalid = 1; rdata = 32'h13;
    tick();
    rvalid = 0;
    #1;
    n_tests++; if (instr_valid !== 1'b1 || instr !== 32'h13 || instr_pc !== 32'h200) begin n_fail++; $display("FAIL flush_new: got v=%b %h@%h want 1 00000013@00000200", instr_valid, instr, instr_pc); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL flush_err_after: got %b want 0", err); end
    instr_ready = 1;
    tick();
    instr_ready = 0;
    #1;
    n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL flush_only_one: got %b want 0", instr_valid); end
  endtask

  task automatic test_orphan();
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL orphan_pre: got %b want 0", err); end
    rvalid = 1; rdata = 32'hDEAD;
    tick();
    rvalid = 0;
    #1;
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL orphan_err: got %b want 1", err); end
    n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL orphan_valid: got %b want 0", instr_valid); end
    for (int i = 0; i < 3; i++) tick();
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL orphan_sticky: got %b want 1", err); end
  endtask

  task automatic test_async_reset();
    req_valid = 1; req_pc = 32'h500; gnt = 1;
    tick();
    req_valid = 0; gnt = 0; rvalid = 1; rdata = 32'h77;
    tick();
    rvalid = 0; req_valid = 1; req_pc = 32'h504; gnt = 1;
    tick();
    #1;
    n_tests++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL areset_pre_valid: got %b want 1", instr_valid); end
    #1;
    rst = 1;
    #1;
    n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid: got %b want 0", instr_valid); end
    n_tests++; if (imem_req !== 1'b0 || req_ready !== 1'b0) begin n_fail++; $display("FAIL areset_req: got req=%b rdy=%b want 0 0", imem_req, req_ready); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL areset_err: got %b want 0", err); end
    idle_inputs();
    tick();
    rst = 0;
    tick();
    req_valid = 1; req_pc = 32'h0; gnt = 1;
    #1;
    n_tests++; if (req_ready !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL areset_fresh_req: got rdy=%b addr=%h want 1 00000000", req_ready, imem_addr); end
    tick();
    req_valid = 0; gnt = 0; rvalid = 1; rdata = 32'hCAFE_0001;
    tick();
    rvalid = 0;
    #1;
    n_tests++; if (instr_valid !== 1'b1 || instr !== 32'hCAFE_0001 || instr_pc !== 32'h0) begin n_fail++; $display("FAIL areset_fresh: got v=%b %h@%h want 1 cafe0001@00000000", instr_valid, instr, instr_pc); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL areset_fresh_err: got %b want 0", err); end
    instr_ready = 1;
    tick();
    instr_ready = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_align();
    test_credit();
    test_flush();
    test_orphan();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_instr_fetch_unit
